// File: rtl/popcount_frame_accumulator.sv
// Frame accumulator for 6-bit popcount values: collects WORDS beats, then presents the saturating sum and the maximum.
// Optional macro POPACC_THRESH_EN adds the thresh_hits output (beats with count >= THRESH).
module popcount_frame_accumulator #(
    parameter int WORDS  = 8,
    parameter int SUM_W  = 9,
    parameter int THRESH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    input  logic [5:0]       in_count,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SUM_W-1:0] out_sum,
    output logic [5:0]       out_max,
    output logic             busy
`ifdef POPACC_THRESH_EN
    ,
    output logic [7:0]       thresh_hits
`endif
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    // Extra headroom so the add can never wrap before the saturation compare.
    localparam int EXT_W = SUM_W + 7;
    localparam logic [EXT_W-1:0] SUM_MAX = {{7{1'b0}}, {SUM_W{1'b1}}};

    if (WORDS < 2 || WORDS > 255 || SUM_W < 1 || THRESH < 0) begin : g_bad_param
        $error("popcount_frame_accumulator: parameter out of range");
    end

    logic [1:0]       state;
    logic [SUM_W-1:0] acc_sum;
    logic [5:0]       acc_max;
    logic [7:0]       word_cnt;

    logic [EXT_W-1:0] sum_ext;
    logic [SUM_W-1:0] sum_next;
    logic [5:0]       max_next;
    logic             last_beat;

    always_comb begin
        sum_ext   = EXT_W'(acc_sum) + EXT_W'(in_count);
        sum_next  = (sum_ext > SUM_MAX) ? {SUM_W{1'b1}} : sum_ext[SUM_W-1:0];
        max_next  = (in_count > acc_max) ? in_count : acc_max;
        last_beat = (word_cnt == 8'(WORDS - 1));
    end

    assign in_ready = (state == S_ACCUM);
    assign busy     = (state == S_ACCUM);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_max   <= '0;
            acc_sum   <= '0;
            acc_max   <= '0;
            word_cnt  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        acc_sum  <= '0;
                        acc_max  <= '0;
                        word_cnt <= '0;
                        state    <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    if (in_valid) begin
                        acc_sum  <= sum_next;
                        acc_max  <= max_next;
                        word_cnt <= word_cnt + 8'd1;
                        if (last_beat) begin
                            out_sum   <= sum_next;
                            out_max   <= max_next;
                            out_valid <= 1'b1;
                            state     <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (start) begin
                            acc_sum  <= '0;
                            acc_max  <= '0;
                            word_cnt <= '0;
                            state    <= S_ACCUM;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef POPACC_THRESH_EN
    logic [7:0] hit_cnt;
    logic [7:0] hit_next;

    always_comb begin
        hit_next = hit_cnt + ((32'(in_count) >= 32'(THRESH)) ? 8'd1 : 8'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt     <= '0;
            thresh_hits <= '0;
        end else if ((state == S_IDLE && start) || (state == S_DONE && out_ready && start)) begin
            hit_cnt <= '0;
        end else if (state == S_ACCUM && in_valid) begin
            hit_cnt <= hit_next;
            if (last_beat) thresh_hits <= hit_next;
        end
    end
`endif

endmodule

// File: tb/tb_popcount_frame_accumulator.sv
// Randomized self-checking bench: two instances (SUM_W=9 and SUM_W=6, WORDS=4) share stimulus and are scored against a frame model.
module tb_popcount_frame_accumulator;

    localparam int WORDS  = 4;
    localparam int THRESH = 16;

    logic clk = 1'b0;
    logic rst, start, in_valid, out_ready;
    logic [5:0] in_count;

    logic       a_in_ready, a_out_valid, a_busy;
    logic [8:0] a_out_sum;
    logic [5:0] a_out_max;
    logic       b_in_ready, b_out_valid, b_busy;
    logic [5:0] b_out_sum;
    logic [5:0] b_out_max;
`ifdef POPACC_THRESH_EN
    logic [7:0] a_hits, b_hits;
`endif

    int checks = 0;
    int errors = 0;
    int frame_cnt[WORDS];
    int exp_sum9, exp_sum6, exp_max, exp_hits;

    always #5 clk = ~clk;

    popcount_frame_accumulator #(.WORDS(WORDS), .SUM_W(9), .THRESH(THRESH)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_count(in_count),
        .in_ready(a_in_ready), .out_valid(a_out_valid), .out_ready(out_ready),
        .out_sum(a_out_sum), .out_max(a_out_max), .busy(a_busy)
`ifdef POPACC_THRESH_EN
        , .thresh_hits(a_hits)
`endif
    );

    popcount_frame_accumulator #(.WORDS(WORDS), .SUM_W(6), .THRESH(THRESH)) dut_sat (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_count(in_count),
        .in_ready(b_in_ready), .out_valid(b_out_valid), .out_ready(out_ready),
        .out_sum(b_out_sum), .out_max(b_out_max), .busy(b_busy)
`ifdef POPACC_THRESH_EN
        , .thresh_hits(b_hits)
`endif
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain arithmetic over the frame's counts.
    task automatic model();
        int s;
        s = 0; exp_max = 0; exp_hits = 0;
        foreach (frame_cnt[i]) begin
            s += frame_cnt[i];
            if (frame_cnt[i] > exp_max) exp_max = frame_cnt[i];
            if (frame_cnt[i] >= THRESH) exp_hits++;
        end
        exp_sum9 = (s > 511) ? 511 : s;
        exp_sum6 = (s > 63) ? 63 : s;
    endtask

    task automatic chk_state(input string tag, input int rdy, input int vld, input int bsy);
        chk({tag, ".in_ready"}, int'(a_in_ready), rdy);
        chk({tag, ".out_valid"}, int'(a_out_valid), vld);
        chk({tag, ".busy"}, int'(a_busy), bsy);
        chk({tag, ".sat_in_ready"}, int'(b_in_ready), rdy);
        chk({tag, ".sat_out_valid"}, int'(b_out_valid), vld);
    endtask

    task automatic chk_result(input string tag);
        chk({tag, ".sum"}, int'(a_out_sum), exp_sum9);
        chk({tag, ".max"}, int'(a_out_max), exp_max);
        chk({tag, ".sat_sum"}, int'(b_out_sum), exp_sum6);
        chk({tag, ".sat_max"}, int'(b_out_max), exp_max);
`ifdef POPACC_THRESH_EN
        chk({tag, ".hits"}, int'(a_hits), exp_hits);
        chk({tag, ".sat_hits"}, int'(b_hits), exp_hits);
`endif
    endtask

    // Feed frame_cnt as WORDS beats; optional start pulse and random gaps.
    task automatic feed(input string tag, input bit do_start, input int gap_max);
        if (do_start) begin
            start = 1'b1; tick(); start = 1'b0;
        end
        chk_state({tag, ".accum"}, 1, 0, 1);
        for (int i = 0; i < WORDS; i++) begin
            int gap;
            gap = (gap_max == 0) ? 0 : int'($urandom_range(gap_max, 0));
            for (int g = 0; g < gap; g++) begin
                in_valid = 1'b0; in_count = 6'($urandom);
                tick();
                chk_state({tag, ".gap"}, 1, 0, 1);
            end
            in_valid = 1'b1; in_count = 6'(frame_cnt[i]);
            tick();
        end
        in_valid = 1'b0;
        model();
        chk_state({tag, ".done"}, 0, 1, 0);
        chk_result(tag);
    endtask

    // Hold DONE with out_ready low while upstream offers junk, then release.
    task automatic hold_release(input string tag, input int hold, input bit next);
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1; in_count = 6'($urandom);
            tick();
            chk_state({tag, ".hold"}, 0, 1, 0);
            chk_result({tag, ".hold"});
        end
        in_valid = 1'b0;
        out_ready = 1'b1; start = next;
        tick();
        out_ready = 1'b0; start = 1'b0;
        if (next) chk_state({tag, ".b2b"}, 1, 0, 1);
        else begin
            chk_state({tag, ".idle"}, 0, 0, 0);
            chk_result({tag, ".kept"});
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_count = '0; out_ready = 1'b0;
        tick(); tick();
        chk_state("reset", 0, 0, 0);
        chk("reset.sum", int'(a_out_sum), 0);
        chk("reset.max", int'(a_out_max), 0);
        chk("reset.sat_sum", int'(b_out_sum), 0);
`ifdef POPACC_THRESH_EN
        chk("reset.hits", int'(a_hits), 0);
`endif
        rst = 1'b0;
        // Beats offered in IDLE must be ignored.
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_count = 6'd40; tick();
            chk_state("idle_ignore", 0, 0, 0);
        end
        in_valid = 1'b0;

        frame_cnt = '{32, 13, 16, 15};
        feed("basic", 1'b1, 0);
        hold_release("basic", 0, 1'b0);

        frame_cnt = '{7, 30, 2, 19};
        feed("stall", 1'b1, 3);
        hold_release("stall", 5, 1'b0);

        frame_cnt = '{32, 32, 32, 32};
        feed("sat", 1'b1, 0);
        hold_release("sat", 1, 1'b1);

        frame_cnt = '{1, 2, 3, 4};
        feed("b2b", 1'b0, 0);
        hold_release("b2b", 0, 1'b0);

        // Reset in the middle of a frame discards partial data.
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_count = 6'd30; tick();
        end
        in_valid = 1'b0; rst = 1'b1; tick(); rst = 1'b0;
        chk_state("midrst", 0, 0, 0);
        chk("midrst.sum", int'(a_out_sum), 0);
        chk("midrst.max", int'(a_out_max), 0);
        frame_cnt = '{5, 5, 5, 5};
        feed("after_rst", 1'b1, 0);
        hold_release("after_rst", 0, 1'b0);

        // Random frames with random gaps, hold times and back-to-back chaining.
        begin
            bit chain;
            chain = 1'b0;
            for (int f = 0; f < 30; f++) begin
                bit next;
                foreach (frame_cnt[i]) frame_cnt[i] = int'($urandom_range(63, 0));
                feed($sformatf("rnd%0d", f), !chain, 2);
                next = 1'($urandom_range(1, 0));
                hold_release($sformatf("rnd%0d", f), int'($urandom_range(3, 0)), next);
                chain = next;
            end
            if (chain) begin
                frame_cnt = '{0, 63, 63, 0};
                feed("tail", 1'b0, 0);
                hold_release("tail", 0, 1'b0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/popcount_frame_accumulator.md
Name: popcount_frame_accumulator

Overview:
Downstream consumer of the 32-bit population counter's 6-bit count output. It collects a frame of WORDS counts over a valid/ready handshake, accumulates their sum and maximum, then presents the frame result until it is taken. Typical use is computing per-frame bit density for display logic.

Parameters:
WORDS, 8, number of counts per frame (2..255)
SUM_W, 9, width of out_sum; values above 2^SUM_W-1 saturate
THRESH, 16, hit threshold, used only when POPACC_THRESH_EN is defined

Ports:
clk  input  1  single clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
start  input  1  begin a new frame (sampled in IDLE, or in DONE together with out_ready)
in_valid  input  1  in_count is valid
in_count  input  6  popcount value from the upstream counter (0..32 nominal, any 6-bit value accepted)
in_ready  output  1  block accepts in_count this cycle
out_valid  output  1  frame result valid
out_ready  input  1  downstream takes the result
out_sum  output  SUM_W  saturating sum of the frame's counts
out_max  output  6  largest count in the frame
busy  output  1  high in ACCUM

Behaviour:
- Reset (rst=1 at an edge): state IDLE; in_ready=0, out_valid=0, busy=0, out_sum=0, out_max=0, internal word counter=0, accumulators=0. Reset mid-frame discards all partial data.
- All outputs are registered; in_ready and busy decode from state.
- IDLE: in_ready=0. start=1 -> clear accumulators and word counter, go to ACCUM. in_ready rises the next cycle. in_valid is ignored.
- ACCUM: in_ready=1, busy=1. A beat is accepted when in_valid & in_ready:
  - acc_sum += in_count, saturating at 2^SUM_W-1, no wrap;
  - acc_max = max(acc_max, in_count);
  - word counter increments.
- Accepting beat WORDS (counter = WORDS-1):
  - the same edge loads out_sum/out_max with the final values including that beat, sets out_valid=1, and moves to DONE;
  - out_valid is visible 1 cycle after the last accepted beat.
- start during ACCUM is ignored. in_valid=0 stalls indefinitely with no timeout.
- DONE: in_ready=0. out_valid, out_sum and out_max are held stable until out_ready=1.
  - out_ready=1, start=0 -> out_valid=0, go to IDLE.
  - out_ready=1, start=1 -> out_valid=0, accumulators cleared, go directly to ACCUM (back-to-back frames).
- out_sum/out_max keep their last values after handshake until the next frame completes or reset.
- in_valid while in_ready=0 is never accepted; upstream must hold its data.

Optional Feature:
Macro POPACC_THRESH_EN.
- Defined: adds output port thresh_hits [7:0].
  - Counts accepted beats with in_count >= THRESH.
  - Cleared on start; latched with out_sum at frame end; held through DONE; reset value 0.
- Not defined: the port and its logic are absent, and the THRESH parameter is unused.

Test Plan:
- Reset then idle: rst=1 for 2 cycles -> in_ready=0, out_valid=0, out_sum=0, out_max=0, busy=0; in_valid pulses without start produce no acceptance.
- Basic frame (WORDS=4): start, then counts 32,13,16,15 on consecutive cycles -> out_valid one cycle after the 4th beat, out_sum=76, out_max=32; with POPACC_THRESH_EN, thresh_hits=2.
- Stall/backpressure: in_valid gaps of 3 cycles between beats, and out_ready held low 5 cycles in DONE -> result unchanged and held; no extra beats accepted; in_ready=0 throughout DONE.
- Saturation (SUM_W=6, WORDS=4): counts 32,32,32,32 -> out_sum=63, out_max=32.
- Back-to-back frames: out_ready=1 with start=1 in DONE -> next cycle busy=1, in_ready=1, out_valid=0; second frame 1,2,3,4 -> out_sum=10, out_max=4 (no carry-over from the first frame).
- Reset mid-frame: after 2 of 4 beats assert rst -> IDLE, all outputs 0; a new frame 5,5,5,5 -> out_sum=20.
